// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM states and stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    localparam int HDR_BYTES = 2;
    localparam int CHK_BYTES = 1;
    localparam int LEN_W     = 8 * HDR_BYTES;
    localparam int CHK_W     = 8 * CHK_BYTES;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts bytes LSB-first into a little-endian word.
// o_word already includes the current byte, so it is valid in the same cycle as o_word_valid.
module byte_packer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [7:0]   i_byte,
    output logic [W-1:0] o_word,
    output logic         o_word_valid
);
    localparam int NB = W / 8;
    localparam int CW = $clog2(NB);

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
            r_sh  <= o_word;
        end
    end

    assign o_word       = {i_byte, r_sh[W-1:8]};
    assign o_word_valid = i_en && (r_cnt == CW'(NB - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader writing a checksummed byte stream into instruction memory,
// holding the datapath in reset until the image is verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int INS_W     = 32,
    parameter int MAX_WORDS = 2 ** (PC_W - 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic             reload,
    output logic             im_we,
    output logic [PC_W-1:0]  im_addr,
    output logic [INS_W-1:0] im_wdata,
    output logic             core_reset,
    output logic             done,
    output logic             err
);
    localparam int IDX_W = PC_W - 2;

    state_t             r_state, w_next;
    logic [7:0]         r_len_lo;
    logic [LEN_W-1:0]   r_len;
    logic [IDX_W-1:0]   r_word_idx;
    logic [CHK_W-1:0]   r_xor;
    logic               r_we;
    logic [PC_W-1:0]    r_addr;
    logic [INS_W-1:0]   r_wdata;
    logic               w_accept, w_reload, w_too_long, w_last, w_word_valid;
    logic [LEN_W-1:0]   w_len;
    logic [INS_W-1:0]   w_word;

    assign w_accept   = rx_valid && rx_ready;
    assign w_reload   = reload && (r_state == S_RUN || r_state == S_ERR);
    assign w_len      = {rx_data, r_len_lo};
    assign w_too_long = {1'b0, w_len} > (LEN_W + 1)'(MAX_WORDS);
    assign w_last     = LEN_W'(r_word_idx) == r_len - LEN_W'(1);

    byte_packer #(.W(INS_W)) u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_reload),
        .i_en         (w_accept && r_state == S_DATA),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_HDR0;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR0:       if (w_accept) w_next = S_HDR1;
            S_HDR1:       if (w_accept) w_next = w_too_long ? S_ERR : (w_len == '0 ? S_CHK : S_DATA);
            S_DATA:       if (w_word_valid && w_last) w_next = S_CHK;
            S_CHK:        if (w_accept) w_next = (rx_data == r_xor) ? S_RUN : S_ERR;
            S_RUN, S_ERR: if (reload) w_next = S_HDR0;
            default:      w_next = S_HDR0;
        endcase
    end

    always_comb begin
        rx_ready   = r_state inside {S_HDR0, S_HDR1, S_DATA, S_CHK};
        core_reset = r_state != S_RUN;
        done       = r_state == S_RUN;
        err        = r_state == S_ERR;
    end

    // Datapath registers: header capture, payload XOR, word index and the memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_xor      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_we <= w_word_valid;
            if (w_word_valid) begin
                r_addr     <= {r_word_idx, 2'b00};
                r_wdata    <= w_word;
                r_word_idx <= r_word_idx + IDX_W'(1);
            end
            if (w_accept && r_state == S_HDR0) r_len_lo <= rx_data;
            if (w_accept && r_state == S_HDR1) r_len <= w_len;
            if (w_accept && r_state == S_DATA) r_xor <= r_xor ^ rx_data;
            if (w_reload) begin
                r_word_idx <= '0;
                r_xor      <= '0;
            end
        end
    end

    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks drive byte streams; expected writes are queued
// as stimulus is sent and matched by a write monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        reload = 1'b0;
    logic        rx_ready, im_we, core_reset, done, err;
    logic [8:0]  im_addr;
    logic [31:0] im_wdata;

    int          checks = 0;
    int          errors = 0;
    logic [40:0] exp_q[$];
    logic [40:0] exp_w;
    logic [8:0]  last_addr = '0;
    logic [31:0] none[$];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && im_we) begin
            checks++;
            last_addr = im_addr;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required no write", im_addr, im_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({im_addr, im_wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                             im_addr, im_wdata, exp_w[40:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int idle);
        int n = 0;
        while (idle > 0 && $urandom_range(99) < idle) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rx_ready) begin
            errors++;
            $display("FAIL rx_ready_timeout got=%b required 1", rx_ready);
        end else @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input logic [31:0] words[$], input int idle, input logic corrupt);
        logic [7:0]  chk = 8'h00;
        logic [7:0]  b;
        logic [15:0] n = 16'(words.size());
        logic [31:0] w;
        send_byte(n[7:0], idle);
        send_byte(n[15:8], idle);
        foreach (words[i]) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                if (k == 3) exp_q.push_back({9'(i * 4), w});
                b = w[8*k +: 8];
                chk ^= b;
                send_byte(b, idle);
            end
        end
        send_byte(corrupt ? (chk ^ 8'h01) : chk, idle);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checks++;
        if ({core_reset, done, err, rx_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL reload_state core_reset/done/err/ready=%b required 1001", {core_reset, done, err, rx_ready});
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({rx_ready, im_we, im_addr, im_wdata, core_reset, done, err} !== {1'b1, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s ready=%b we=%b addr=%h data=%h core_reset=%b done=%b err=%b required 1 0 000 00000000 1 0 0",
                     tag, rx_ready, im_we, im_addr, im_wdata, core_reset, done, err);
        end
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err, input logic [8:0] e_last);
        checks++;
        if ({done, err, core_reset, rx_ready} !== {e_done, e_err, ~e_done, 1'b0}) begin
            errors++;
            $display("FAIL %s done/err/core_reset/ready=%b required %b", tag,
                     {done, err, core_reset, rx_ready}, {e_done, e_err, ~e_done, 1'b0});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_writes got=%0d required 0", tag, exp_q.size());
        end
        checks++;
        if (last_addr !== e_last) begin
            errors++;
            $display("FAIL %s_last_addr got=%h required %h", tag, last_addr, e_last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_in");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset_out");
    endtask

    task automatic test_two_words();
        logic [31:0] w[$] = '{32'h00A00513, 32'h00B00593};
        send_image(w, 0, 1'b0);
        check_status("two_words", 1'b1, 1'b0, 9'h004);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        check_status("run_hold", 1'b1, 1'b0, 9'h004);
    endtask

    task automatic test_zero_len();
        last_addr = '0;
        pulse_reload();
        send_image(none, 0, 1'b0);
        check_status("zero_len_ok", 1'b1, 1'b0, 9'h000);
        pulse_reload();
        send_image(none, 0, 1'b1);
        check_status("zero_len_bad", 1'b0, 1'b1, 9'h000);
    endtask

    task automatic test_too_long();
        pulse_reload();
        send_byte(8'h81, 0);
        send_byte(8'h00, 0);
        check_status("too_long", 1'b0, 1'b1, 9'h000);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        check_status("err_hold", 1'b0, 1'b1, 9'h000);
    endtask

    task automatic test_random_gaps();
        logic [31:0] w[$];
        for (int i = 0; i < 128; i++) w.push_back($urandom);
        pulse_reload();
        send_image(w, 30, 1'b0);
        check_status("max_image", 1'b1, 1'b0, 9'h1FC);
    endtask

    task automatic test_bad_then_reload();
        logic [31:0] w[$] = '{32'hDEADBEEF};
        pulse_reload();
        send_image(w, 0, 1'b1);
        check_status("bad_chk", 1'b0, 1'b1, 9'h000);
        w[0] = 32'h12345678;
        pulse_reload();
        send_image(w, 0, 1'b0);
        check_status("reload_ok", 1'b1, 1'b0, 9'h000);
    endtask

    task automatic test_async_reset();
        logic [31:0] w[$] = '{32'hCAFEF00D, 32'h0BADC0DE};
        pulse_reload();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back({9'h000, w[0]});
            send_byte(w[0][8*k +: 8], 0);
        end
        send_byte(w[1][7:0], 0);
        send_byte(w[1][15:8], 0);
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("after_async");
        w = '{32'h11223344, 32'h55667788};
        send_image(w, 0, 1'b0);
        check_status("post_reset_load", 1'b1, 1'b0, 9'h004);
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_too_long();
        test_random_gaps();
        test_bad_then_reload();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
